// File: rtl/scan_sequencer.sv
// scan_sequencer
//   Drives one scan-test pattern onto the CSoC scan pins for each start pulse.
//   A pattern has CHAIN_LEN shift cycles with scan enable high. Each shift
//   consumes one scan-in byte (8 parallel chains) and returns one scan-out
//   byte. It is followed by CAPTURE_PULSES capture clocks with scan enable low.
//   The scan-out bytes of a pattern are the response to the previous pattern,
//   because unload overlaps load. This block is the only source of csoc_clk.
//
// Ports
//   clk, rst            system clock; asynchronous active-high reset
//   start / abort       begin a pattern (IDLE only) / return to IDLE at once
//   tm_en, csoc_rst_req registered straight through to csoc_test_tm / csoc_rstn
//   busy, done          not-IDLE flag / one-cycle pattern completion pulse
//   si_*                scan-in byte stream (valid/ready)
//   so_*                scan-out byte stream (valid/ready)
//   csoc_*              CSoC scan pins
//
// Optional build macro SCAN_SIG_EN
//   Adds output sig[15:0], a CRC-16-CCITT (poly 0x1021, init 0xFFFF,
//   MSB-first) over every scan-out byte accepted since the last start.
//
// Every output is registered, so csoc_clk cannot glitch.
module scan_sequencer #(
  parameter int CHAIN_LEN      = 64,
  parameter int CLK_DIV        = 4,
  parameter int CAPTURE_PULSES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        tm_en,
  input  logic        csoc_rst_req,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  si_data,
  input  logic        si_valid,
  output logic        si_ready,
  output logic [7:0]  so_data,
  output logic        so_valid,
  input  logic        so_ready,
  output logic        csoc_clk,
  output logic        csoc_rstn,
  output logic        csoc_test_se,
  output logic        csoc_test_tm,
  output logic [7:0]  csoc_data_o,
  input  logic [7:0]  csoc_data_i
`ifdef SCAN_SIG_EN
  ,
  output logic [15:0] sig
`endif
);

  localparam logic [15:0] LAST_SHIFT = 16'(CHAIN_LEN - 1);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [1:0]  LAST_PULSE = 2'(CAPTURE_PULSES - 1);

  typedef enum logic [2:0] {
    IDLE, SI_WAIT, SH_LO, SH_HI, SO_PUSH, CAP_LO, CAP_HI, DONE
  } state_t;

  state_t      state_q;
  logic [15:0] shift_cnt_q;
  logic [15:0] div_cnt_q;
  logic [1:0]  pulse_cnt_q;
  logic [7:0]  so_buf_q;
  logic        busy_q, done_q, si_ready_q, so_valid_q;
  logic [7:0]  so_data_q, data_o_q;
  logic        clk_q, se_q, rstn_q, tm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      div_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      so_buf_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      si_ready_q  <= 1'b0;
      so_valid_q  <= 1'b0;
      so_data_q   <= '0;
      data_o_q    <= '0;
      clk_q       <= 1'b0;
      se_q        <= 1'b0;
      rstn_q      <= 1'b0;
      tm_q        <= 1'b0;
    end else begin
      rstn_q <= ~csoc_rst_req;
      tm_q   <= tm_en;
      done_q <= 1'b0;
      if (abort) begin
        // csoc_data_o is left alone: the pins keep the last shifted byte.
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        si_ready_q <= 1'b0;
        so_valid_q <= 1'b0;
        clk_q      <= 1'b0;
        se_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q     <= SI_WAIT;
              shift_cnt_q <= '0;
              busy_q      <= 1'b1;
              se_q        <= 1'b1;
              si_ready_q  <= 1'b1;
            end
          end
          SI_WAIT: begin
            // The chain output is sampled before this shift's rising edge.
            // Dropping ready here admits exactly one byte per shift.
            if (si_valid && si_ready_q) begin
              data_o_q   <= si_data;
              so_buf_q   <= csoc_data_i;
              si_ready_q <= 1'b0;
              div_cnt_q  <= '0;
              state_q    <= SH_LO;
            end
          end
          SH_LO: begin
            if (div_cnt_q == DIV_LAST) begin
              clk_q     <= 1'b1;
              div_cnt_q <= '0;
              state_q   <= SH_HI;
            end else begin
              div_cnt_q <= div_cnt_q + 16'd1;
            end
          end
          SH_HI: begin
            if (div_cnt_q == DIV_LAST) begin
              clk_q      <= 1'b0;
              so_valid_q <= 1'b1;
              so_data_q  <= so_buf_q;
              state_q    <= SO_PUSH;
            end else begin
              div_cnt_q <= div_cnt_q + 16'd1;
            end
          end
          SO_PUSH: begin
            if (so_ready) begin
              so_valid_q  <= 1'b0;
              shift_cnt_q <= shift_cnt_q + 16'd1;
              if (shift_cnt_q == LAST_SHIFT) begin
                // Scan enable drops a full low phase before the capture edge.
                se_q        <= 1'b0;
                div_cnt_q   <= '0;
                pulse_cnt_q <= '0;
                state_q     <= CAP_LO;
              end else begin
                si_ready_q <= 1'b1;
                state_q    <= SI_WAIT;
              end
            end
          end
          CAP_LO: begin
            if (div_cnt_q == DIV_LAST) begin
              clk_q     <= 1'b1;
              div_cnt_q <= '0;
              state_q   <= CAP_HI;
            end else begin
              div_cnt_q <= div_cnt_q + 16'd1;
            end
          end
          CAP_HI: begin
            if (div_cnt_q == DIV_LAST) begin
              clk_q     <= 1'b0;
              div_cnt_q <= '0;
              if (pulse_cnt_q == LAST_PULSE) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                pulse_cnt_q <= pulse_cnt_q + 2'd1;
                state_q     <= CAP_LO;
              end
            end else begin
              div_cnt_q <= div_cnt_q + 16'd1;
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef SCAN_SIG_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (!abort) begin
      if (state_q == IDLE && start)          sig_d = 16'hFFFF;
      else if (state_q == SO_PUSH && so_ready) sig_d = crc16_byte(sig_q, so_data_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 16'hFFFF;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign si_ready     = si_ready_q;
  assign so_valid     = so_valid_q;
  assign so_data      = so_data_q;
  assign csoc_clk     = clk_q;
  assign csoc_rstn    = rstn_q;
  assign csoc_test_se = se_q;
  assign csoc_test_tm = tm_q;
  assign csoc_data_o  = data_o_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer. The main instance has CHAIN_LEN=4 and
// CLK_DIV=2, and it runs against a CSoC model: 8 parallel 4-bit chains,
// modelled bytewise. Capture inverts the chain contents. A second instance
// checks CAPTURE_PULSES=2. With SCAN_SIG_EN, a third instance checks the
// signature.
module tb_scan_sequencer;
  localparam int CL = 4;
  localparam int CD = 2;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic       tm_en = 1'b0, csoc_rst_req = 1'b0;
  logic [7:0] si_data = 8'h00;
  logic       si_valid = 1'b0, so_ready = 1'b0;
  logic       busy, done, si_ready, so_valid, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
  logic [7:0] so_data, csoc_data_o, csoc_data_i;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

`ifdef SCAN_SIG_EN
  logic [15:0] sig1, sig3;
`endif

  scan_sequencer #(.CHAIN_LEN(CL), .CLK_DIV(CD), .CAPTURE_PULSES(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .tm_en(tm_en),
    .csoc_rst_req(csoc_rst_req), .busy(busy), .done(done),
    .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready),
    .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
    .csoc_test_tm(csoc_test_tm), .csoc_data_o(csoc_data_o), .csoc_data_i(csoc_data_i)
`ifdef SCAN_SIG_EN
    , .sig(sig1)
`endif
  );

  // CSoC model: chain[31:24] is the scan-out end. Preload gives A1,B2,C3,D4.
  logic [31:0] chain = 32'hA1B2C3D4;
  always @(posedge csoc_clk) begin
    if (csoc_test_se) chain <= {chain[23:0], csoc_data_o};
    else              chain <= ~chain;
  end
  assign csoc_data_i = chain[31:24];

  // Edge counters and waveform monitors for the main instance
  int se1_e = 0, se0_e = 0, done_n = 0;
  int hi_bad = 0, lo_bad = 0, dat_bad = 0, so_bad = 0, run = 0;
  logic mon_en = 1'b1, cc_prev = 1'b0, sov_prev = 1'b0;
  logic [7:0] d_prev = 8'h00, sod_prev = 8'h00;

  always @(posedge csoc_clk) begin
    if (csoc_test_se) se1_e++;
    else              se0_e++;
  end

  always @(negedge clk) begin
    if (csoc_clk == cc_prev) run++;
    else begin
      if (mon_en && cc_prev && run != CD) hi_bad++;
      if (mon_en && !cc_prev && run < CD) lo_bad++;
      run = 1;
    end
    cc_prev = csoc_clk;
    if (mon_en && csoc_clk && csoc_data_o != d_prev) dat_bad++;
    d_prev = csoc_data_o;
    if (mon_en && sov_prev && so_valid && so_data != sod_prev) so_bad++;
    sov_prev = so_valid;
    sod_prev = so_data;
    if (done) done_n++;
  end

  // Second instance: two capture pulses, free-running streams
  logic       start2 = 1'b0, si_valid2 = 1'b1, so_ready2 = 1'b1;
  logic [7:0] si_data2 = 8'h5A, csoc_data_i2 = 8'h00;
  logic       busy2, done2, si_ready2, so_valid2, csoc_clk2, csoc_rstn2, se2, tm2;
  logic [7:0] so_data2, csoc_data_o2;
  int c2_1 = 0, c2_0 = 0;

  scan_sequencer #(.CHAIN_LEN(CL), .CLK_DIV(CD), .CAPTURE_PULSES(2)) u_cap2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .tm_en(tm_en),
    .csoc_rst_req(csoc_rst_req), .busy(busy2), .done(done2),
    .si_data(si_data2), .si_valid(si_valid2), .si_ready(si_ready2),
    .so_data(so_data2), .so_valid(so_valid2), .so_ready(so_ready2),
    .csoc_clk(csoc_clk2), .csoc_rstn(csoc_rstn2), .csoc_test_se(se2),
    .csoc_test_tm(tm2), .csoc_data_o(csoc_data_o2), .csoc_data_i(csoc_data_i2)
`ifdef SCAN_SIG_EN
    , .sig()
`endif
  );

  always @(posedge csoc_clk2) begin
    if (se2) c2_1++;
    else     c2_0++;
  end

`ifdef SCAN_SIG_EN
  // Third instance: chain returns 0x31..0x39 ("123456789")
  logic       start3 = 1'b0, si_valid3 = 1'b1, so_ready3 = 1'b1;
  logic [7:0] si_data3 = 8'h00, csoc_data_i3;
  logic       busy3, done3, si_ready3, so_valid3, csoc_clk3, csoc_rstn3, se3, tm3;
  logic [7:0] so_data3, csoc_data_o3;
  int e3 = 0;

  scan_sequencer #(.CHAIN_LEN(9), .CLK_DIV(1), .CAPTURE_PULSES(1)) u_sig (
    .clk(clk), .rst(rst), .start(start3), .abort(abort), .tm_en(tm_en),
    .csoc_rst_req(csoc_rst_req), .busy(busy3), .done(done3),
    .si_data(si_data3), .si_valid(si_valid3), .si_ready(si_ready3),
    .so_data(so_data3), .so_valid(so_valid3), .so_ready(so_ready3),
    .csoc_clk(csoc_clk3), .csoc_rstn(csoc_rstn3), .csoc_test_se(se3),
    .csoc_test_tm(tm3), .csoc_data_o(csoc_data_o3), .csoc_data_i(csoc_data_i3),
    .sig(sig3)
  );

  always @(posedge csoc_clk3) if (se3) e3++;
  assign csoc_data_i3 = 8'h31 + 8'(e3);
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one scan-in byte and return at the negedge after its handshake.
  task automatic si_push(input logic [7:0] b, input string tag);
    int to = 0;
    si_data  = b;
    si_valid = 1'b1;
    while (!si_ready && to < 100) begin @(negedge clk); to++; end
    chk({tag, "_si_timeout"}, 32'(to < 100), 1);
    @(negedge clk);
    si_valid = 1'b0;
  endtask

  // Wait for a scan-out byte, optionally stall so_ready, then accept it.
  task automatic so_pop(input int stall, input string tag, output logic [7:0] got);
    int to = 0, bad = 0;
    while (!so_valid && to < 100) begin @(negedge clk); to++; end
    chk({tag, "_so_timeout"}, 32'(to < 100), 1);
    got = so_data;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (csoc_clk || !so_valid || so_data !== got) bad++;
    end
    if (stall > 0) chk({tag, "_so_stall"}, bad, 0);
    so_ready = 1'b1;
    @(negedge clk);
    so_ready = 1'b0;
  endtask

  task automatic run_pat(input logic [31:0] si_w, input logic [31:0] so_w, input int si_stall_at,
                         input int so_stall_at, input logic mid_start, input string tag);
    int e1, e0, dn, to, bad;
    logic [7:0] got;
    e1 = se1_e; e0 = se0_e; dn = done_n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    for (int i = 0; i < CL; i++) begin
      if (i == si_stall_at) begin
        bad = 0;
        for (int k = 0; k < 20; k++) begin
          start = mid_start && (k == 0);
          @(negedge clk);
          if (csoc_clk || !busy) bad++;
        end
        start = 1'b0;
        chk({tag, "_si_stall"}, bad, 0);
      end
      si_push(si_w[31-8*i -: 8], tag);
      so_pop((i == so_stall_at) ? 15 : 0, tag, got);
      chk($sformatf("%s_so%0d", tag, i), got, so_w[31-8*i -: 8]);
    end
    to = 0;
    while (!done && to < 100) begin @(negedge clk); to++; end
    chk({tag, "_done_seen"}, 32'(to < 100), 1);
    chk({tag, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy, done}, 0);
    chk({tag, "_se1_edges"}, se1_e - e1, CL);
    chk({tag, "_se0_edges"}, se0_e - e0, 1);
    chk({tag, "_done_pulses"}, done_n - dn, 1);
  endtask

  initial begin
    logic [7:0] got;
    int e1, dn, to;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, si_ready, so_valid, csoc_clk, csoc_test_se, csoc_test_tm, csoc_rstn}, 0);
    chk("rst_so_data", so_data, 0);
    chk("rst_data_o", csoc_data_o, 0);
    rst = 1'b0;
    tm_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("tm_follow", csoc_test_tm, 1);
    chk("rstn_follow", csoc_rstn, 1);

    // Pattern 1 unloads the preload. Pattern 2 flushes the inverted pattern-1 load.
    run_pat(32'h11223344, 32'hA1B2C3D4, -1, -1, 1'b0, "p1");
    run_pat(32'h00000000, 32'hEEDDCCBB, -1, -1, 1'b0, "p2");
    // Stalls on both streams and a stray start mid-pattern
    run_pat(32'h55667788, 32'hFFFFFFFF, 1, 2, 1'b1, "p3");

    // Abort during the high phase of shift 2
    e1 = se1_e; dn = done_n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    si_push(8'h12, "ab");
    so_pop(0, "ab", got);
    chk("ab_so0", got, 8'hAA);
    si_push(8'h34, "ab");
    to = 0;
    while (!csoc_clk && to < 50) begin @(negedge clk); to++; end
    chk("ab_hi_seen", 32'(to < 50), 1);
    mon_en = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_ctl", {csoc_clk, csoc_test_se, busy, si_ready, so_valid, done}, 0);
    chk("ab_data_hold", csoc_data_o, 8'h34);
    chk("ab_edges", se1_e - e1, 2);
    repeat (5) @(negedge clk);
    chk("ab_no_done", done_n - dn, 0);
    chk("ab_idle", busy, 0);
    mon_en = 1'b1;

    // The chain holds 88,77,12,34 after the aborted pattern.
    run_pat(32'h00000000, 32'h88771234, -1, -1, 1'b0, "p5");

    chk("hi_phase", hi_bad, 0);
    chk("lo_phase", lo_bad, 0);
    chk("data_o_while_low", dat_bad, 0);
    chk("so_data_stable", so_bad, 0);

    // Two capture pulses
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    to = 0;
    while (!done2 && to < 300) begin @(negedge clk); to++; end
    chk("cap2_done_seen", 32'(to < 300), 1);
    chk("cap2_se1_edges", c2_1, CL);
    chk("cap2_se0_edges", c2_0, 2);

`ifdef SCAN_SIG_EN
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    to = 0;
    while (!done3 && to < 300) begin @(negedge clk); to++; end
    chk("sig_done_seen", 32'(to < 300), 1);
    chk("sig_crc", sig3, 16'h29B1);
`endif

    // csoc_rst_req is registered: one cycle of latency
    @(negedge clk);
    csoc_rst_req = 1'b1;
    #1 chk("rstn_latency", csoc_rstn, 1);
    @(negedge clk);
    chk("rstn_low", csoc_rstn, 0);
    csoc_rst_req = 1'b0;
    @(negedge clk);
    chk("rstn_high", csoc_rstn, 1);

    // Asynchronous reset during a shift high phase
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    si_push(8'hA5, "rs");
    to = 0;
    while (!csoc_clk && to < 50) begin @(negedge clk); to++; end
    chk("rs_hi_seen", 32'(to < 50), 1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rs_ctl", {busy, done, si_ready, so_valid, csoc_clk, csoc_test_se, csoc_test_tm, csoc_rstn}, 0);
    chk("rs_data", {so_data, csoc_data_o}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
